mem_wb_stage: RTL and testbench

- Memory stage plus MEM/WB pipeline register of the 5-stage MIPS core.
- Consumes the EX/MEM latch outputs and drives the dcache request (dmemREN/dmemWEN/dmemaddr/dmemstore). Stalls upstream until dhit.
- Holds the LL/SC link register with snoop invalidation.
- Registers write-back controls, halt and data for the WB stage.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/link_reg.sv | 51 +++++
 rtl/mem_wb_stage.sv | 134 +++++++++++++
 tb/tb_mem_wb_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and constants for the MIPS core pipeline
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // Memory stage sequencing: DONE parks a finished access until EX/MEM advances.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Write-back source selects
    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC  = 2'b10;
    localparam logic [1:0] WSEL_LUI = 2'b11;

endpackage

// File: rtl/link_reg.sv
// rtl/link_reg.sv - LL/SC link register with snoop invalidation
//
// Purpose: tracks the address reserved by the last LL and reports whether an SC
// evaluated this cycle may succeed.
// Ports:
//   CLK, nRST          clock, synchronous active-low reset
//   ll_done            an LL completes this cycle (addr is its address)
//   sc_done            an SC completes this cycle (success or failure)
//   sw_done            a plain store completes this cycle at addr
//   addr               address of the instruction in MEM
//   snoop_inv          coherence invalidate, snoop_addr is the invalidated word
//   sc_ok              an SC at addr would succeed this cycle
module link_reg #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ll_done,
    input  logic              sc_done,
    input  logic              sw_done,
    input  logic [WORD_W-1:0] addr,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              sc_ok
);

    logic              link_valid;
    logic [WORD_W-1:0] link_addr;
    logic              snoop_hit;
    logic              addr_hit;

    assign snoop_hit = snoop_inv & (snoop_addr == link_addr);
    assign addr_hit  = (link_addr == addr);

    // A snoop landing in the same cycle as the SC already kills the reservation.
    assign sc_ok = link_valid & addr_hit & ~snoop_hit;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (ll_done) begin
            // A new reservation wins over a simultaneous snoop of the old one.
            link_valid <= 1'b1;
            link_addr  <= addr;
        end else if (sc_done || (sw_done && addr_hit) || snoop_hit) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage and MEM/WB pipeline register
//
// Purpose: issues the dcache request for the instruction in MEM, stalls the
// front of the pipe until dhit, handles LL/SC and latches write-back state.
// Ports:
//   CLK, nRST                      clock, synchronous active-low reset
//   *_MEM                          EX/MEM latch outputs
//   advance                        EX/MEM takes a new instruction at next edge
//   flush                          squash the instruction in MEM
//   dhit, dload                    dcache completion and read data
//   snoop_inv, snoop_addr          coherence invalidate
//   dmemREN/WEN/addr/store         dcache request
//   mem_stall                      freeze IF..EX/MEM
//   RegWr_WB, wsel_WB, wdat_WB     registered write-back controls
//   halt_WB                        sticky registered halt
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              RegWr_MEM,
    input  logic              memtoReg_MEM,
    input  logic              memWr_MEM,
    input  logic              datomic_MEM,
    input  logic              halt_MEM,
    input  logic [1:0]        Wsel_MEM,
    input  logic [WORD_W-1:0] Output_Port_MEM,
    input  logic [WORD_W-1:0] busB_MEM,
    input  logic [WORD_W-1:0] next_addr_MEM,
    input  logic [WORD_W-1:0] extended_MEM,
    input  logic [REG_W-1:0]  final_wsel_MEM,
    input  logic              advance,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              RegWr_WB,
    output logic [REG_W-1:0]  wsel_WB,
    output logic [WORD_W-1:0] wdat_WB,
    output logic              halt_WB
);

    mem_state_t        state, state_next;
    logic              is_sc;
    logic              is_ll;
    logic              sc_ok;
    logic              is_sc_fail;
    logic              active;
    logic              latch;
    logic [WORD_W-1:0] wdat_next;

    assign is_sc      = memWr_MEM & datomic_MEM;
    assign is_ll      = memtoReg_MEM & datomic_MEM;
    assign is_sc_fail = is_sc & ~sc_ok;

    // DONE means the access already happened; never re-issue it.
    assign active = (state != DONE) & ~flush;

    assign dmemREN   = memtoReg_MEM & active;
    assign dmemWEN   = memWr_MEM & ~is_sc_fail & active;
    assign dmemaddr  = Output_Port_MEM;
    assign dmemstore = busB_MEM;
    assign mem_stall = (dmemREN | dmemWEN) & ~dhit;

    // Instruction retires into MEM/WB this cycle; otherwise a bubble is loaded.
    assign latch = active & ~mem_stall;

    link_reg #(.WORD_W(WORD_W)) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .ll_done    (latch & is_ll),
        .sc_done    (latch & is_sc),
        .sw_done    (latch & memWr_MEM & ~datomic_MEM),
        .addr       (Output_Port_MEM),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .sc_ok      (sc_ok)
    );

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else if (state == DONE) begin
            if (advance) state_next = IDLE;
        end else if (mem_stall) begin
            state_next = WAIT;
        end else begin
            state_next = advance ? IDLE : DONE;
        end
    end

    always_comb begin
        wdat_next = Output_Port_MEM;
        case (Wsel_MEM)
            WSEL_ALU: wdat_next = Output_Port_MEM;
            WSEL_MEM: wdat_next = dload;
            WSEL_PC:  wdat_next = next_addr_MEM;
            WSEL_LUI: wdat_next = extended_MEM;
            default:  wdat_next = Output_Port_MEM;
        endcase
        if (is_sc) wdat_next = {{(WORD_W-1){1'b0}}, sc_ok};
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            RegWr_WB <= 1'b0;
            wsel_WB  <= '0;
            wdat_WB  <= '0;
            halt_WB  <= 1'b0;
        end else begin
            state <= state_next;
            if (latch) begin
                RegWr_WB <= RegWr_MEM;
                wsel_WB  <= final_wsel_MEM;
                wdat_WB  <= wdat_next;
                if (halt_MEM) halt_WB <= 1'b1;
            end else begin
                RegWr_WB <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        RegWr_MEM, memtoReg_MEM, memWr_MEM, datomic_MEM, halt_MEM;
    logic [1:0]  Wsel_MEM;
    logic [31:0] Output_Port_MEM, busB_MEM, next_addr_MEM, extended_MEM;
    logic [4:0]  final_wsel_MEM;
    logic        advance, flush, dhit;
    logic [31:0] dload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dmemREN, dmemWEN, mem_stall;
    logic [31:0] dmemaddr, dmemstore;
    logic        RegWr_WB, halt_WB;
    logic [4:0]  wsel_WB;
    logic [31:0] wdat_WB;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST),
        .RegWr_MEM(RegWr_MEM), .memtoReg_MEM(memtoReg_MEM), .memWr_MEM(memWr_MEM),
        .datomic_MEM(datomic_MEM), .halt_MEM(halt_MEM), .Wsel_MEM(Wsel_MEM),
        .Output_Port_MEM(Output_Port_MEM), .busB_MEM(busB_MEM),
        .next_addr_MEM(next_addr_MEM), .extended_MEM(extended_MEM),
        .final_wsel_MEM(final_wsel_MEM), .advance(advance), .flush(flush),
        .dhit(dhit), .dload(dload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .RegWr_WB(RegWr_WB),
        .wsel_WB(wsel_WB), .wdat_WB(wdat_WB), .halt_WB(halt_WB)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        regwr, mtr, mwr, dat, fl, hit;
        logic [1:0]  wsel;
        logic [31:0] op, busb, nxt, ext, ld;
        logic        e_ren, e_wen, e_stall, e_regwr;
        logic [31:0] e_wdat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in;
        RegWr_MEM = 0; memtoReg_MEM = 0; memWr_MEM = 0; datomic_MEM = 0; halt_MEM = 0;
        Wsel_MEM = WSEL_ALU; Output_Port_MEM = 0; busB_MEM = 0; next_addr_MEM = 0;
        extended_MEM = 0; final_wsel_MEM = 0; advance = 1; flush = 0; dhit = 0;
        dload = 0; snoop_inv = 0; snoop_addr = 0;
    endtask

    task automatic set_instr(input logic rw, input logic mtr, input logic mwr, input logic dat,
                             input logic [1:0] ws, input logic [31:0] op, input logic [31:0] bb,
                             input logic [4:0] dst);
        RegWr_MEM = rw; memtoReg_MEM = mtr; memWr_MEM = mwr; datomic_MEM = dat;
        Wsel_MEM = ws; Output_Port_MEM = op; busB_MEM = bb; final_wsel_MEM = dst;
    endtask

    // LL to addr that completes in one cycle, then a nop slot
    task automatic do_ll(input logic [31:0] a, input logic snoop_same);
        clear_in;
        set_instr(1, 1, 0, 1, WSEL_MEM, a, 0, 6);
        dhit = 1; dload = 32'h77;
        snoop_inv = snoop_same; snoop_addr = a;
        tick;
        clear_in;
    endtask

    initial begin
        // regwr mtr mwr dat fl hit wsel op busb nxt ext ld | ren wen stall regwr wdat
        vecs[0] = '{1,0,0,0,0,0, WSEL_ALU, 32'h1234, 32'h9, 32'h44, 32'hABCD0000, 32'h0,         0,0,0,1, 32'h1234};
        vecs[1] = '{1,0,0,0,0,0, WSEL_PC,  32'h1234, 32'h9, 32'h44, 32'hABCD0000, 32'h0,         0,0,0,1, 32'h44};
        vecs[2] = '{1,0,0,0,0,0, WSEL_LUI, 32'h1234, 32'h9, 32'h44, 32'hABCD0000, 32'h0,         0,0,0,1, 32'hABCD0000};
        vecs[3] = '{1,1,0,0,0,1, WSEL_MEM, 32'h100,  32'h0, 32'h0,  32'h0,        32'hCAFEF00D,  1,0,0,1, 32'hCAFEF00D};
        vecs[4] = '{0,0,1,0,0,1, WSEL_ALU, 32'h300,  32'h55,32'h0,  32'h0,        32'h0,         0,1,0,0, 32'h0};
        vecs[5] = '{1,1,0,0,1,1, WSEL_MEM, 32'h104,  32'h0, 32'h0,  32'h0,        32'h1111,      0,0,0,0, 32'h0};
        vecs[6] = '{0,0,1,0,1,0, WSEL_ALU, 32'h308,  32'h66,32'h0,  32'h0,        32'h0,         0,0,0,0, 32'h0};
        vecs[7] = '{0,0,0,0,0,0, WSEL_ALU, 32'h5,    32'h6, 32'h0,  32'h0,        32'h0,         0,0,0,0, 32'h0};

        // Reset state
        clear_in;
        nRST = 0;
        tick; tick;
        chk("reset_regwr", {31'b0, RegWr_WB}, 0);
        chk("reset_wsel",  {27'b0, wsel_WB}, 0);
        chk("reset_wdat",  wdat_WB, 0);
        chk("reset_halt",  {31'b0, halt_WB}, 0);
        chk("reset_ren",   {31'b0, dmemREN}, 0);
        nRST = 1;
        tick;

        // Single-cycle vectors
        for (int i = 0; i < 8; i++) begin
            clear_in;
            set_instr(vecs[i].regwr, vecs[i].mtr, vecs[i].mwr, vecs[i].dat, vecs[i].wsel,
                      vecs[i].op, vecs[i].busb, 5'(i + 1));
            next_addr_MEM = vecs[i].nxt; extended_MEM = vecs[i].ext;
            flush = vecs[i].fl; dhit = vecs[i].hit; dload = vecs[i].ld;
            #3;
            chk($sformatf("v%0d_ren", i),   {31'b0, dmemREN}, {31'b0, vecs[i].e_ren});
            chk($sformatf("v%0d_wen", i),   {31'b0, dmemWEN}, {31'b0, vecs[i].e_wen});
            chk($sformatf("v%0d_stall", i), {31'b0, mem_stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_addr", i),  dmemaddr, vecs[i].op);
            chk($sformatf("v%0d_store", i), dmemstore, vecs[i].busb);
            tick;
            chk($sformatf("v%0d_regwr", i), {31'b0, RegWr_WB}, {31'b0, vecs[i].e_regwr});
            if (vecs[i].e_regwr) begin
                chk($sformatf("v%0d_wdat", i), wdat_WB, vecs[i].e_wdat);
                chk($sformatf("v%0d_wsel", i), {27'b0, wsel_WB}, i + 1);
            end
        end

        // LW with three miss cycles
        clear_in; tick;
        set_instr(1, 1, 0, 0, WSEL_MEM, 32'h100, 0, 3);
        advance = 0; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("lw_stall%0d", i), {31'b0, mem_stall}, 1);
            chk($sformatf("lw_ren%0d", i), {31'b0, dmemREN}, 1);
            tick;
            chk($sformatf("lw_bubble%0d", i), {31'b0, RegWr_WB}, 0);
        end
        dhit = 1; dload = 32'hDEADBEEF; advance = 1;
        #3;
        chk("lw_stall_hit", {31'b0, mem_stall}, 0);
        tick;
        chk("lw_regwr", {31'b0, RegWr_WB}, 1);
        chk("lw_wdat", wdat_WB, 32'hDEADBEEF);
        chk("lw_wsel", {27'b0, wsel_WB}, 3);

        // LL then SC success, then repeated SC fails
        do_ll(32'h200, 0);
        chk("ll_wdat", wdat_WB, 32'h77);
        set_instr(1, 0, 1, 1, WSEL_ALU, 32'h200, 32'h5, 7);
        dhit = 1;
        #3;
        chk("sc_ok_wen", {31'b0, dmemWEN}, 1);
        chk("sc_ok_store", dmemstore, 32'h5);
        tick;
        chk("sc_ok_regwr", {31'b0, RegWr_WB}, 1);
        chk("sc_ok_wdat", wdat_WB, 1);
        dhit = 0;
        #3;
        chk("sc_again_wen", {31'b0, dmemWEN}, 0);
        chk("sc_again_stall", {31'b0, mem_stall}, 0);
        tick;
        chk("sc_again_regwr", {31'b0, RegWr_WB}, 1);
        chk("sc_again_wdat", wdat_WB, 0);

        // Snoop between LL and SC
        do_ll(32'h200, 0);
        snoop_inv = 1; snoop_addr = 32'h200;
        tick;
        clear_in;
        set_instr(1, 0, 1, 1, WSEL_ALU, 32'h200, 32'h5, 7);
        #3;
        chk("snp_sc_wen", {31'b0, dmemWEN}, 0);
        chk("snp_sc_stall", {31'b0, mem_stall}, 0);
        tick;
        chk("snp_sc_wdat", wdat_WB, 0);

        // Snoop in the same cycle as the SC
        do_ll(32'h200, 0);
        set_instr(1, 0, 1, 1, WSEL_ALU, 32'h200, 32'h5, 7);
        dhit = 1; snoop_inv = 1; snoop_addr = 32'h200;
        #3;
        chk("snp_same_wen", {31'b0, dmemWEN}, 0);
        tick;
        chk("snp_same_wdat", wdat_WB, 0);

        // Snoop in the same cycle as the LL: LL wins
        do_ll(32'h200, 1);
        set_instr(1, 0, 1, 1, WSEL_ALU, 32'h200, 32'h5, 7);
        dhit = 1;
        #3;
        chk("llwin_wen", {31'b0, dmemWEN}, 1);
        tick;
        chk("llwin_wdat", wdat_WB, 1);

        // Plain SW to the link address clears it
        do_ll(32'h500, 0);
        set_instr(0, 0, 1, 0, WSEL_ALU, 32'h500, 32'h1, 0);
        dhit = 1;
        tick;
        clear_in;
        set_instr(1, 0, 1, 1, WSEL_ALU, 32'h500, 32'h5, 7);
        #3;
        chk("sw_clr_wen", {31'b0, dmemWEN}, 0);
        tick;
        chk("sw_clr_wdat", wdat_WB, 0);

        // Snoop to a neighbouring word leaves the link intact
        do_ll(32'h600, 0);
        snoop_inv = 1; snoop_addr = 32'h604;
        tick;
        clear_in;
        set_instr(1, 0, 1, 1, WSEL_ALU, 32'h600, 32'h5, 7);
        dhit = 1;
        #3;
        chk("snp_other_wen", {31'b0, dmemWEN}, 1);
        tick;
        chk("snp_other_wdat", wdat_WB, 1);

        // SW held by an external stall: one write pulse, then DONE
        clear_in;
        set_instr(0, 0, 1, 0, WSEL_ALU, 32'h300, 32'h99, 0);
        advance = 0; dhit = 1;
        #3;
        chk("hold_wen0", {31'b0, dmemWEN}, 1);
        tick;
        #3;
        chk("hold_wen1", {31'b0, dmemWEN}, 0);
        chk("hold_stall1", {31'b0, mem_stall}, 0);
        tick;
        chk("hold_regwr1", {31'b0, RegWr_WB}, 0);
        advance = 1;
        #3;
        chk("hold_wen2", {31'b0, dmemWEN}, 0);
        tick;
        clear_in;
        set_instr(1, 1, 0, 0, WSEL_MEM, 32'h310, 0, 2);
        dhit = 1;
        #3;
        chk("hold_next_ren", {31'b0, dmemREN}, 1);
        tick;

        // ALU instr held: one valid write-back, then bubbles
        clear_in;
        set_instr(1, 0, 0, 0, WSEL_ALU, 32'hABC, 0, 9);
        advance = 0;
        tick;
        chk("alu_hold_first", {31'b0, RegWr_WB}, 1);
        tick;
        chk("alu_hold_bubble", {31'b0, RegWr_WB}, 0);
        advance = 1;
        tick;

        // Flush in WAIT of LW 0x400
        clear_in;
        set_instr(1, 1, 0, 0, WSEL_MEM, 32'h400, 0, 4);
        advance = 0; dhit = 0;
        tick;
        flush = 1;
        #3;
        chk("flush_ren", {31'b0, dmemREN}, 0);
        chk("flush_stall", {31'b0, mem_stall}, 0);
        tick;
        chk("flush_bubble", {31'b0, RegWr_WB}, 0);
        flush = 0;
        #3;
        chk("flush_idle_ren", {31'b0, dmemREN}, 1);
        dhit = 1; dload = 32'h4444; advance = 1;
        tick;
        chk("flush_retry_wdat", wdat_WB, 32'h4444);

        // Halt: flushed halt ignored, latched halt sticky until reset
        clear_in;
        set_instr(1, 0, 0, 0, WSEL_ALU, 32'h1, 0, 1);
        halt_MEM = 1; flush = 1;
        tick;
        chk("halt_flushed", {31'b0, halt_WB}, 0);
        flush = 0;
        tick;
        chk("halt_set", {31'b0, halt_WB}, 1);
        clear_in;
        tick; tick;
        chk("halt_sticky", {31'b0, halt_WB}, 1);
        nRST = 0;
        tick;
        chk("halt_rst", {31'b0, halt_WB}, 0);
        chk("halt_rst_regwr", {31'b0, RegWr_WB}, 0);
        chk("halt_rst_wdat", wdat_WB, 0);
        chk("halt_rst_wsel", {27'b0, wsel_WB}, 0);
        nRST = 1;
        tick;

        // Reset mid-WAIT clears the link
        do_ll(32'h700, 0);
        set_instr(1, 1, 0, 0, WSEL_MEM, 32'h704, 0, 1);
        advance = 0;
        tick;
        nRST = 0;
        clear_in;
        tick;
        chk("rst_wait_ren", {31'b0, dmemREN}, 0);
        nRST = 1;
        set_instr(1, 0, 1, 1, WSEL_ALU, 32'h700, 32'h5, 7);
        #3;
        chk("rst_link_wen", {31'b0, dmemWEN}, 0);
        tick;
        chk("rst_link_wdat", wdat_WB, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
